keypad_scanner: RTL
===================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 active-low matrix keypad, debounces presses/releases and encodes the
//  key into the 8-bit key code + level 'pressed' consumed by the calculator FSM.
//  Sits directly upstream of the calculator FSM; its key_code/pressed drive the FSM's in/pressed.
//  key_code is stable for the whole time pressed=1.
// PARAMETERS
//  SCAN_DIV  16  clk cycles each column is driven (dwell); must be >= 4
//  DEBOUNCE  4   consecutive identical samples required to accept press or release; >= 1
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  row_in     in   4  keypad rows, active-low (pulled up), asynchronous to clk
//  col_out    out  4  column drive, active-low, exactly one bit low at any time
//  key_code   out  8  encoded key; holds last accepted key after release
//  pressed    out  1  high while a debounced key is held (level)
//  key_strobe out  1  one-cycle pulse in the cycle pressed rises
// BEHAVIOUR
//  Reset (async, rst_n=0): col_out=4'b1110, key_code=8'h00, pressed=0, key_strobe=0,
//   state=SCAN, dwell/debounce counters=0. Takes effect immediately, mid-operation included.
//  row_in passes a 2-flop synchroniser; all decisions use the synchronised value.
//  Sample point = last cycle of each SCAN_DIV dwell period (dwell counter = SCAN_DIV-1).
//  Key map [row][col] -> code:
//   r0: '1'=8'h01 '2'=8'h02 '3'=8'h03 '+'=8'h81
//   r1: '4'=8'h04 '5'=8'h05 '6'=8'h06 '-'=8'h82
//   r2: '7'=8'h07 '8'=8'h08 '9'=8'h09 '*'=8'h84
//   r3: 'C'=8'h41 '0'=8'h00 '='=8'h48 '/'=8'h88
//  States:
//   SCAN: rotate col_out 1110->1101->1011->0111->1110 after each sample point. If any row
//    is low at a sample: latch (row,col), cnt=1, go DEBOUNCE, freeze column.
//    Multiple rows low: lowest row index wins.
//   DEBOUNCE: at each sample, same row low -> cnt+1; otherwise cnt=0, back to SCAN at next column.
//    When cnt reaches DEBOUNCE: next cycle pressed=1, key_strobe=1 (1 cycle),
//    key_code=map(row,col); go HELD. DEBOUNCE=1 accepts on the detecting sample.
//   HELD: column stays frozen. Sample latched row released (high) -> cnt=1, go RELEASE.
//    Keys in other columns are never seen (no rollover); other rows in same column ignored.
//   RELEASE: released sample -> cnt+1; latched row low again -> return to HELD, cnt=0, no strobe.
//    When cnt reaches DEBOUNCE: pressed=0 next cycle, go SCAN resuming at next column.
//  Latency: steady key from first detecting sample to pressed=1 = (DEBOUNCE-1)*SCAN_DIV+1 clk.
//   Release latency is the same measured from the first released sample.
//  key_code changes only in the cycle key_strobe is high.
//  At most one key_strobe per debounced press, regardless of bounce.
//  Counters: dwell $clog2(SCAN_DIV) bits, debounce $clog2(DEBOUNCE+1) bits; saturate, never wrap.
// TESTING  (bench uses SCAN_DIV=4, DEBOUNCE=3, keypad model driving row_in from col_out)
//  1 Reset: rst_n=0 mid-HELD -> pressed=0, key_strobe=0, col_out=1110 without a clk edge;
//    key_code=00; scanning restarts at col 0 after rst_n=1.
//  2 Hold '3' (r0,c2) 200 clk -> single key_strobe, pressed=1, key_code=8'h03 within
//    one scan round + 9 clk; release -> pressed=0 9 clk after first released sample.
//  3 Sequence 3,5,-,4,5,= with gaps -> key_code 03,05,82,04,05,48, one strobe each,
//    pressed low between keys.
//  4 Bounce: '=' toggles every sample for 6 samples then steady -> exactly one strobe, code 8'h48;
//    a glitch of 2 samples only -> pressed never rises.
//  5 '5' and '8' together (same col 1) -> code 8'h05; while '5' held press '+' (col 3)
//    -> ignored, key_code stays 8'h05.
//  6 Release bounce: held '9' released with 2 re-press samples -> pressed stays 1, no new strobe,
//    falls only after 3 consecutive released samples.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: rotates the column drive, debounces the
// latched key over SCAN_DIV-spaced samples and emits key_code / pressed / key_strobe.
module keypad_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] key_code,
  output logic       pressed,
  output logic       key_strobe,
  output logic [1:0] dbg_state
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      row_s1_q, row_s2_q;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            pressed_q, pressed_d;
  logic            strobe_q, strobe_d;

  logic            sample;
  logic [3:0]      row_low;
  logic [1:0]      first_row;
  logic            latched_low;
  logic [CW-1:0]   cnt_inc;
  logic            cnt_done;

  function automatic logic [7:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [7:0] code;
    case ({r, c})
      4'h0: code = 8'h01;  4'h1: code = 8'h02;  4'h2: code = 8'h03;  4'h3: code = 8'h81;
      4'h4: code = 8'h04;  4'h5: code = 8'h05;  4'h6: code = 8'h06;  4'h7: code = 8'h82;
      4'h8: code = 8'h07;  4'h9: code = 8'h08;  4'hA: code = 8'h09;  4'hB: code = 8'h84;
      4'hC: code = 8'h41;  4'hD: code = 8'h00;  4'hE: code = 8'h48;  default: code = 8'h88;
    endcase
    return code;
  endfunction

  // Decisions are taken only on the last cycle of each column dwell.
  assign sample      = (dwell_q == DW'(SCAN_DIV - 1));
  assign dwell_d     = sample ? '0 : dwell_q + DW'(1);
  assign row_low     = ~row_s2_q;
  assign latched_low = row_low[row_q];
  assign cnt_inc     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign cnt_done    = (cnt_inc >= CW'(DEBOUNCE));

  always_comb begin
    first_row = 2'd3;
    if      (row_low[0]) first_row = 2'd0;
    else if (row_low[1]) first_row = 2'd1;
    else if (row_low[2]) first_row = 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    key_code_d = key_code_q;
    pressed_d  = pressed_q;
    strobe_d   = 1'b0;
    if (sample) begin
      case (state_q)
        ST_SCAN: begin
          if (|row_low) begin
            row_d = first_row;
            cnt_d = CW'(1);
            if (DEBOUNCE == 1) begin
              state_d    = ST_HELD;
              cnt_d      = '0;
              pressed_d  = 1'b1;
              strobe_d   = 1'b1;
              key_code_d = key_map(first_row, col_q);
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (latched_low) begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              state_d    = ST_HELD;
              cnt_d      = '0;
              pressed_d  = 1'b1;
              strobe_d   = 1'b1;
              key_code_d = key_map(row_q, col_q);
            end
          end else begin
            state_d = ST_SCAN;
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
          end
        end
        ST_HELD: begin
          // Only the latched row of the frozen column matters here.
          if (!latched_low) begin
            cnt_d = CW'(1);
            if (DEBOUNCE == 1) begin
              state_d   = ST_SCAN;
              cnt_d     = '0;
              pressed_d = 1'b0;
              col_d     = col_q + 2'd1;
            end else begin
              state_d = ST_RELEASE;
            end
          end
        end
        default: begin
          if (!latched_low) begin
            cnt_d = cnt_inc;
            if (cnt_done) begin
              state_d   = ST_SCAN;
              cnt_d     = '0;
              pressed_d = 1'b0;
              col_d     = col_q + 2'd1;
            end
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q   <= 4'hF;
      row_s2_q   <= 4'hF;
      dwell_q    <= '0;
      state_q    <= ST_SCAN;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      cnt_q      <= '0;
      key_code_q <= 8'h00;
      pressed_q  <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      row_s1_q   <= row_in;
      row_s2_q   <= row_s1_q;
      dwell_q    <= dwell_d;
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      key_code_q <= key_code_d;
      pressed_q  <= pressed_d;
      strobe_q   <= strobe_d;
    end
  end

  assign col_out    = ~(4'b0001 << col_q);
  assign key_code   = key_code_q;
  assign pressed    = pressed_q;
  assign key_strobe = strobe_q;
  assign dbg_state  = state_q;

endmodule
